alarm_ring_ctrl: RTL and testbench
==================================

Name: alarm_ring_ctrl

Overview:
Downstream consumer of the clock/alarm counter's 1-bit `alarm` match level. It turns that level into a user-facing alarm session: a ringing pattern, snooze handling, stop handling and an auto-timeout. It drives the buzzer pin and status outputs toward the board I/O wrapper. All timing is counted in clk cycles, the same time base as the counter stage.

Parameters:
BEEP_ON, 2, cycles buzzer is high per beep period
BEEP_OFF, 2, cycles buzzer is low per beep period
RING_TIMEOUT, 32, cycles of continuous RINGING before auto-dismiss
SNOOZE_CYCLES, 16, cycles spent in SNOOZE before ringing resumes
MAX_SNOOZE, 3, snoozes allowed per session (≤3, fits snooze_cnt)
CNT_W, 8, width of the shared phase/timer counters (must hold max(RING_TIMEOUT, SNOOZE_CYCLES, BEEP_ON+BEEP_OFF)-1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
en  in  1  block enable; 0 forces IDLE
alarm_in  in  1  alarm match level from the clock counter stage
snooze_req  in  1  snooze request, sampled as a level each cycle
stop_req  in  1  stop request, sampled as a level each cycle
buzzer  out  1  beep pattern output
ringing  out  1  high while state == RINGING
snoozed  out  1  high while state == SNOOZE
state  out  2  current FSM state encoding
snooze_cnt  out  2  snoozes used in the current session
missed  out  1  1-cycle pulse on auto-timeout dismissal

Behaviour:
- Reset (rst_n=1, async): state=IDLE, all counters=0, alarm_in_d=0, snooze_cnt=0, missed=0. Hence buzzer=0, ringing=0, snoozed=0.
- alarm_in_d registers alarm_in every cycle, regardless of state or en.
- Trigger condition: rise = alarm_in & ~alarm_in_d.
- State encoding: IDLE=0, RINGING=1, SNOOZE=2, DISMISSED=3.
- IDLE:
  - en & rise -> RINGING next cycle.
  - On that transition: snooze_cnt=0, ring_timer=0, beep_phase=0.
- RINGING, evaluated in priority order:
  1. stop_req -> DISMISSED.
  2. snooze_req & snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt+1; timer=0.
  3. ring_timer==RING_TIMEOUT-1 -> DISMISSED, with missed=1 for exactly one cycle.
  4. Otherwise: ring_timer+1; beep_phase increments and wraps at BEEP_ON+BEEP_OFF-1 -> 0.
- snooze_req with snooze_cnt==MAX_SNOOZE is ignored; the block keeps ringing and the timer keeps running.
- SNOOZE, evaluated in priority order:
  1. stop_req -> DISMISSED.
  2. timer==SNOOZE_CYCLES-1 -> RINGING with ring_timer=0 and beep_phase=0.
  3. Otherwise: timer+1.
  - snooze_req has no effect in SNOOZE.
- DISMISSED:
  - Stays until alarm_in==0, then IDLE. This prevents retriggering while the hours/minutes match persists.
  - snooze_cnt is held until the transition to IDLE, where it is cleared.
- Outputs:
  - buzzer = (state==RINGING) & (beep_phase < BEEP_ON). Combinational from registers, so it is high on the first RINGING cycle.
  - ringing, snoozed and state decode directly from the state register.
- en=0 from any state -> IDLE next cycle; counters and snooze_cnt cleared; missed=0. en has priority over all other inputs.
- Re-enabling while alarm_in is already high does not trigger, because there is no rising edge.
- Simultaneous stop_req & snooze_req: stop wins.
- Simultaneous stop_req with the timeout cycle: stop wins, and missed stays 0.
- Latency: alarm_in rise at cycle N -> ringing=1 and buzzer=1 at N+1.
- Counter arithmetic is unsigned CNT_W; no counter ever exceeds its terminal value.
- Reset asserted mid-session returns all outputs to reset values immediately. After release, a new session needs a fresh alarm_in rise.

Decomposition:
- Shared package alarm_pkg:
  - state enum (IDLE/RINGING/SNOOZE/DISMISSED, 2-bit).
  - Default timing constants used by both this block and the top wrapper.
- One natural sub-module: alarm_beep_gen.
  - Owns beep_phase and the buzzer decode.
  - Inputs: clk, rst_n, clear, run.
  - Output: buzzer.
- FSM, timers and snooze accounting remain in alarm_ring_ctrl.

Test Plan:
- Basic ring: en=1, alarm_in 0->1 at cycle 10 -> ringing=1 at 11; buzzer pattern 1,1,0,0 repeating from cycle 11.
- Timeout: no requests after trigger -> DISMISSED at cycle 11+32=43; missed=1 for cycle 43 only; buzzer=0. Drop alarm_in at 50 -> IDLE at 51.
- Snooze limit:
  - Pulse snooze_req one cycle, three times, each while RINGING -> snooze_cnt 1,2,3; each SNOOZE lasts 16 cycles, then ringing resumes with beep_phase=0.
  - A fourth snooze_req -> ignored; state stays RINGING.
- Stop priority: snooze_req=1 and stop_req=1 in the same RINGING cycle -> DISMISSED next cycle; snooze_cnt unchanged; missed=0.
- No retrigger: after stop, hold alarm_in=1 for 20 cycles -> state stays DISMISSED, buzzer=0; alarm_in 1->0->1 -> IDLE, then RINGING again with snooze_cnt=0.
- Enable/reset:
  - en=0 while SNOOZE -> IDLE next cycle.
  - en=1 with alarm_in still high -> no ring.
  - rst_n=1 pulse mid-RINGING -> buzzer, ringing and state=0 asynchronously.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared alarm session types and default timing.
// Used by the ring controller and the board wrapper.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RINGING   = 2'd1,
    ST_SNOOZE    = 2'd2,
    ST_DISMISSED = 2'd3
  } state_e;

  localparam int DEF_BEEP_ON       = 2;
  localparam int DEF_BEEP_OFF      = 2;
  localparam int DEF_RING_TIMEOUT  = 32;
  localparam int DEF_SNOOZE_CYCLES = 16;
  localparam int DEF_MAX_SNOOZE    = 3;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/alarm_beep_gen.sv
// Beep pattern generator: phase counter plus buzzer decode.
// Phase restarts at zero whenever clear is held.
module alarm_beep_gen
  import alarm_pkg::*;
#(
  parameter int BEEP_ON  = DEF_BEEP_ON,
  parameter int BEEP_OFF = DEF_BEEP_OFF,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic buzzer
);

  localparam logic [CNT_W-1:0] PH_LAST =
    CNT_W'(BEEP_ON + BEEP_OFF - 1);
  localparam logic [CNT_W-1:0] PH_ON = CNT_W'(BEEP_ON);

  logic [CNT_W-1:0] phase_q;

  // Phase advances while ringing, wrapping at the period end.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      phase_q <= '0;
    end else if (clear) begin
      phase_q <= '0;
    end else if (run) begin
      if (phase_q == PH_LAST) phase_q <= '0;
      else                    phase_q <= phase_q + 1'b1;
    end
  end

  // High for the first BEEP_ON cycles of each period.
  always_comb begin
    buzzer = run & (phase_q < PH_ON);
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm session FSM: ring, snooze, stop and auto-timeout.
// Reset is active-high on rst_n and asynchronous.
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int BEEP_ON       = DEF_BEEP_ON,
  parameter int BEEP_OFF      = DEF_BEEP_OFF,
  parameter int RING_TIMEOUT  = DEF_RING_TIMEOUT,
  parameter int SNOOZE_CYCLES = DEF_SNOOZE_CYCLES,
  parameter int MAX_SNOOZE    = DEF_MAX_SNOOZE,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       alarm_in,
  input  logic       snooze_req,
  input  logic       stop_req,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed,
  output logic [1:0] state,
  output logic [1:0] snooze_cnt,
  output logic       missed
);

  localparam logic [CNT_W-1:0] RT_LAST =
    CNT_W'(RING_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SN_LAST =
    CNT_W'(SNOOZE_CYCLES - 1);
  localparam logic [1:0] SN_MAX = 2'(MAX_SNOOZE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             missed_d;
  logic             alarm_in_d;
  logic             rise;
  logic             in_ring;
  logic             beep_clear;

  assign rise = alarm_in & ~alarm_in_d;

  // Edge-detect history, independent of state and enable.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) alarm_in_d <= 1'b0;
    else       alarm_in_d <= alarm_in;
  end

  // Session state, shared timer and snooze accounting.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      missed  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      missed  <= missed_d;
    end
  end

  // Next-state logic; enable overrides everything.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    missed_d = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      timer_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_RINGING;
            timer_d = '0;
            cnt_d   = '0;
          end
        end
        ST_RINGING: begin
          if (stop_req) begin
            state_d = ST_DISMISSED;
            timer_d = '0;
          end else if (snooze_req && cnt_q < SN_MAX) begin
            state_d = ST_SNOOZE;
            timer_d = '0;
            cnt_d   = cnt_q + 2'd1;
          end else if (timer_q == RT_LAST) begin
            state_d  = ST_DISMISSED;
            timer_d  = '0;
            missed_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (stop_req) begin
            state_d = ST_DISMISSED;
            timer_d = '0;
          end else if (timer_q == SN_LAST) begin
            state_d = ST_RINGING;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_DISMISSED: begin
          if (!alarm_in) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign in_ring    = (state_q == ST_RINGING);
  assign beep_clear = ~en | ~in_ring;

  alarm_beep_gen #(
    .BEEP_ON  (BEEP_ON),
    .BEEP_OFF (BEEP_OFF),
    .CNT_W    (CNT_W)
  ) u_beep (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (beep_clear),
    .run    (in_ring),
    .buzzer (buzzer)
  );

  // Status decode straight from the state register.
  always_comb begin
    ringing    = in_ring;
    snoozed    = (state_q == ST_SNOOZE);
    state      = state_q;
    snooze_cnt = cnt_q;
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_alarm_ring_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       alarm_in;
  logic       snooze_req;
  logic       stop_req;
  logic       buzzer;
  logic       ringing;
  logic       snoozed;
  logic [1:0] state;
  logic [1:0] snooze_cnt;
  logic       missed;

  int total = 0;
  int bad   = 0;

  alarm_ring_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .alarm_in   (alarm_in),
    .snooze_req (snooze_req),
    .stop_req   (stop_req),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozed    (snoozed),
    .state      (state),
    .snooze_cnt (snooze_cnt),
    .missed     (missed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    en         = 1'b0;
    alarm_in   = 1'b0;
    snooze_req = 1'b0;
    stop_req   = 1'b0;
    #12;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_buzzer", 8'(buzzer), 8'd0);
    chk("rst_ringing", 8'(ringing), 8'd0);
    chk("rst_snoozed", 8'(snoozed), 8'd0);
    chk("rst_cnt", 8'(snooze_cnt), 8'd0);
    chk("rst_missed", 8'(missed), 8'd0);
    rst_n = 1'b0;
    en    = 1'b1;
    tick();
    tick();
    chk("idle_hold", 8'(state), 8'd0);

    // basic ring and beep pattern
    alarm_in = 1'b1;
    tick();
    chk("ring_state", 8'(state), 8'd1);
    chk("ring_flag", 8'(ringing), 8'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("beep_%0d", i), 8'(buzzer),
          ((i % 4) < 2) ? 8'd1 : 8'd0);
      tick();
    end
    for (int i = 8; i < 32; i++) begin
      if (state !== 2'd1)
        chk($sformatf("ring_idx_%0d", i), 8'(state), 8'd1);
      tick();
    end
    chk("to_state", 8'(state), 8'd3);
    chk("to_missed", 8'(missed), 8'd1);
    chk("to_buzzer", 8'(buzzer), 8'd0);
    tick();
    chk("to_missed_pulse", 8'(missed), 8'd0);
    chk("to_hold", 8'(state), 8'd3);
    alarm_in = 1'b0;
    tick();
    chk("to_idle", 8'(state), 8'd0);

    // three snoozes, then a fourth is ignored
    alarm_in = 1'b1;
    tick();
    chk("s_ring", 8'(state), 8'd1);
    chk("s_cnt0", 8'(snooze_cnt), 8'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      snooze_req = 1'b1;
      tick();
      snooze_req = 1'b0;
      chk($sformatf("s%0d_state", k), 8'(state), 8'd2);
      chk($sformatf("s%0d_snz", k), 8'(snoozed), 8'd1);
      chk($sformatf("s%0d_cnt", k), 8'(snooze_cnt), 8'(k));
      chk($sformatf("s%0d_buz", k), 8'(buzzer), 8'd0);
      repeat (15) tick();
      chk($sformatf("s%0d_last", k), 8'(state), 8'd2);
      tick();
      chk($sformatf("s%0d_resume", k), 8'(state), 8'd1);
      chk($sformatf("s%0d_ph0", k), 8'(buzzer), 8'd1);
      tick();
      chk($sformatf("s%0d_ph1", k), 8'(buzzer), 8'd1);
      tick();
      chk($sformatf("s%0d_ph2", k), 8'(buzzer), 8'd0);
    end
    snooze_req = 1'b1;
    tick();
    snooze_req = 1'b0;
    chk("s4_ignored", 8'(state), 8'd1);
    chk("s4_cnt", 8'(snooze_cnt), 8'd3);

    // stop beats snooze
    stop_req   = 1'b1;
    snooze_req = 1'b1;
    tick();
    stop_req   = 1'b0;
    snooze_req = 1'b0;
    chk("stop_state", 8'(state), 8'd3);
    chk("stop_cnt", 8'(snooze_cnt), 8'd3);
    chk("stop_missed", 8'(missed), 8'd0);

    // no retrigger while alarm held
    repeat (20) tick();
    chk("hold_state", 8'(state), 8'd3);
    chk("hold_buz", 8'(buzzer), 8'd0);
    alarm_in = 1'b0;
    tick();
    chk("rearm_idle", 8'(state), 8'd0);
    chk("rearm_cnt", 8'(snooze_cnt), 8'd0);
    alarm_in = 1'b1;
    tick();
    chk("rering", 8'(state), 8'd1);
    chk("rering_cnt", 8'(snooze_cnt), 8'd0);

    // disable during snooze, re-enable with alarm high
    snooze_req = 1'b1;
    tick();
    snooze_req = 1'b0;
    chk("en_snz", 8'(state), 8'd2);
    en = 1'b0;
    tick();
    chk("en_off_idle", 8'(state), 8'd0);
    chk("en_off_cnt", 8'(snooze_cnt), 8'd0);
    en = 1'b1;
    repeat (3) tick();
    chk("en_no_ring", 8'(state), 8'd0);

    // stop on the timeout cycle suppresses missed
    alarm_in = 1'b0;
    tick();
    alarm_in = 1'b1;
    tick();
    chk("st_ring", 8'(state), 8'd1);
    repeat (31) tick();
    chk("st_last", 8'(state), 8'd1);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    chk("st_dism", 8'(state), 8'd3);
    chk("st_missed", 8'(missed), 8'd0);
    alarm_in = 1'b0;
    tick();

    // async reset mid-ring
    alarm_in = 1'b1;
    tick();
    chk("ar_ring", 8'(state), 8'd1);
    chk("ar_buz", 8'(buzzer), 8'd1);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ar_state", 8'(state), 8'd0);
    chk("ar_ringing", 8'(ringing), 8'd0);
    chk("ar_buzzer", 8'(buzzer), 8'd0);
    alarm_in = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("ar_after", 8'(state), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
